bidir_pin_responder: RTL
========================

Name: bidir_pin_responder

Overview:
- Half-duplex single-wire responder for one shared tristate GPIO on the ECP5 board, clocked from the 48 MHz system clock.
- Receives a UART-style frame from the far-end initiator, then waits a turnaround gap.
- After the gap it takes the pin and drives back a response frame, then releases the pin to Hi-Z.
- Top level connects pin_o/pin_oe to a TRELLIS_IO BIDIR primitive, with T = ~pin_oe, and pin_i from its O output.

Parameters:
- BIT_CYCLES, 48, clk48 cycles per bit (1 Mbit/s); must be >= 4.
- TURN_CYCLES, 96, idle cycles with pin_oe=0 between received stop sample and response start bit; must be >= 1.

Ports:
- clk48  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pin_i  input  1  raw pad input (asynchronous; synchronized internally)
- pin_o  output  1  pad output data
- pin_oe  output  1  1 = drive pad, 0 = Hi-Z
- resp_en  input  1  1 = send response after a good frame
- resp_data  input  8  response byte; sampled in the rx_valid cycle
- rx_data  output  8  last good received byte; held until the next good frame
- rx_valid  output  1  one-cycle pulse, good frame received
- frame_err  output  1  one-cycle pulse on stop (or parity) error
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): pin_o=1, pin_oe=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, synchronizer flops=1.
- Synchronizer: 2 flops, so pin_i reaches the logic 2 cycles late.
- Line format: idle high; start=0; 8 data bits LSB first; stop=1.
- pin_oe is 1 only in TX_START, TX_DATA and TX_STOP.

State machine:
- IDLE: a synchronized high-to-low edge loads the bit counter with BIT_CYCLES/2 and moves to RX_START.
- RX_START: at mid-bit the line must still be 0, then go to RX_DATA. If the line is 1, it was a glitch: return to IDLE with no pulse.
- RX_DATA: sample every BIT_CYCLES; shift in LSB first; after 8 samples go to RX_STOP.
- RX_STOP: sample after BIT_CYCLES.
  - Sample is 1: assert rx_valid in the next cycle, update rx_data in that same cycle, latch resp_data.
    - If resp_en=1, go to TURN; otherwise go to IDLE.
  - Sample is 0: pulse frame_err, go to WAIT_HIGH. rx_data is unchanged and no response is sent.
- WAIT_HIGH: stay until the synchronized line is 1, then go to IDLE. This prevents re-triggering on a stuck-low line.
- TURN: count TURN_CYCLES with pin_oe=0. Line edges are ignored; there is no reception during TURN or TX.
- TX_START: drive 0 for BIT_CYCLES.
- TX_DATA: drive 8 bits LSB first, BIT_CYCLES each.
- TX_STOP: drive 1 for BIT_CYCLES, then pin_oe=0 and go to IDLE. Driving 1 before release avoids a floating low.
- Bit counter: width $clog2(BIT_CYCLES+1); wraps only by reload, never free-running. The bit index is 4 bits.
- resp_data changes after the latch cycle do not affect the frame in flight.
- rst_n asserted mid-frame (RX or TX): the pin is released immediately (pin_oe=0 asynchronously) and all outputs take their reset values.

Optional Feature:
- Macro: BIDIR_RESP_PARITY_EN.
- Defined:
  - Both directions carry an even-parity bit after bit 7, before stop.
  - RX parity mismatch pulses frame_err in the cycle after the stop sample and does not update rx_data.
  - After a parity error the block sends no response and returns to IDLE (or WAIT_HIGH if stop was also bad).
  - TX appends even parity of the latched byte.
- Undefined: 8N1 exactly as above; no parity logic is present.

Decomposition:
- Package bidir_link_pkg holds:
  - state enum (IDLE, RX_START, RX_DATA, RX_STOP, WAIT_HIGH, TURN, TX_START, TX_DATA, TX_STOP)
  - DATA_BITS=8
  - LINE_IDLE=1'b1
- One sub-module, bidir_sync: 2-flop synchronizer with a reset value parameter (set to 1 here).
- Counter and shift register stay in the top FSM.

Test Plan (BIT_CYCLES=8, TURN_CYCLES=16 for simulation):
- Reset mid-TX: assert rst_n=0 during TX_DATA -> pin_oe=0 in the same cycle; pin_o=1, busy=0; the next valid frame is received normally.
- Good frame 0xA5, resp_en=1, resp_data=0x3C:
  - rx_valid pulses once with rx_data=0xA5; pin_oe stays 0 for 16 cycles.
  - Then the pin carries the bit sequence 0,0,0,1,1,1,1,0,0,1, each bit 8 cycles; then pin_oe=0 and busy=0.
- Glitch: low pulse of 3 cycles on an idle line -> no rx_valid, no frame_err, back to IDLE, pin_oe never 1.
- Bad stop: frame 0x55 with stop=0, line held low 40 cycles then high -> one frame_err pulse; rx_data keeps its prior value; no TX; IDLE only after the line returns high.
- resp_en=0 with good frame 0xFF -> rx_valid pulse, rx_data=0xFF, pin_oe never asserted; a back-to-back second frame 0x01 is received correctly.
- With BIDIR_RESP_PARITY_EN defined, frame 0x03 with parity=1 -> frame_err pulse, no response; with parity=0 -> rx_valid pulse and the response carries the correct parity bit.

Source files
------------

// File: rtl/bidir_link_pkg.sv
// Shared types and constants for the single-wire half-duplex responder.
// Parity support in the top level is enabled with the BIDIR_RESP_PARITY_EN macro.
package bidir_link_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        LINE_IDLE = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        WAIT_HIGH,
        TURN,
        TX_START,
        TX_DATA,
        TX_STOP
    } state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bidir_sync.sv
// Two-flop synchronizer for an asynchronous pad input, with a selectable reset level.
module bidir_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/bidir_pin_responder.sv
// Half-duplex single-wire responder: receive a UART-style frame, wait a turnaround gap, reply.
// Define BIDIR_RESP_PARITY_EN to add an even-parity bit after bit 7 in both directions.
module bidir_pin_responder
    import bidir_link_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 48,
    parameter int unsigned TURN_CYCLES = 96
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       pin_i,
    output logic       pin_o,
    output logic       pin_oe,
    input  logic       resp_en,
    input  logic [7:0] resp_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W  = $clog2(BIT_CYCLES + 1);
    localparam int unsigned TURN_W = $clog2(TURN_CYCLES + 1);
`ifdef BIDIR_RESP_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned FRAME_BITS = DATA_BITS + PAR_BITS;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(BIT_CYCLES / 2);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [TURN_W-1:0] TURN_FULL = TURN_W'(TURN_CYCLES);
    localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
    localparam logic [3:0]        IDX_LAST  = 4'(FRAME_BITS - 1);

    state_e                  r_state;
    state_e                  w_state_d;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_d;
    logic [TURN_W-1:0]       r_turn;
    logic [TURN_W-1:0]       w_turn_d;
    logic [3:0]              r_idx;
    logic [3:0]              w_idx_d;
    logic [FRAME_BITS-1:0]   r_rx_shift;
    logic [FRAME_BITS-1:0]   w_rx_shift_d;
    logic [FRAME_BITS-1:0]   r_tx_shift;
    logic [FRAME_BITS-1:0]   w_tx_shift_d;
    logic [DATA_BITS-1:0]    r_rx_data;
    logic [DATA_BITS-1:0]    w_rx_data_d;
    logic                    r_rx_valid;
    logic                    w_rx_valid_d;
    logic                    r_frame_err;
    logic                    w_frame_err_d;
    logic                    r_pin_o;
    logic                    w_pin_o_d;
    logic                    r_pin_oe;
    logic                    w_pin_oe_d;
    logic                    r_line_prev;

    logic                    w_line;
    logic                    w_cnt_hit;
    logic                    w_par_ok;
    logic [FRAME_BITS-1:0]   w_tx_load;

    bidir_sync #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .i_clk   (clk48),
        .i_rst_n (rst_n),
        .i_d     (pin_i),
        .o_q     (w_line)
    );

`ifdef BIDIR_RESP_PARITY_EN
    // Data plus received parity must XOR to zero for even parity.
    assign w_par_ok  = ~(^r_rx_shift);
    assign w_tx_load = {even_parity(resp_data), resp_data};
`else
    assign w_par_ok  = 1'b1;
    assign w_tx_load = resp_data;
`endif

    assign w_cnt_hit = (r_cnt == CNT_ONE);

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_turn_d      = r_turn;
        w_idx_d       = r_idx;
        w_rx_shift_d  = r_rx_shift;
        w_tx_shift_d  = r_tx_shift;
        w_rx_data_d   = r_rx_data;
        w_rx_valid_d  = 1'b0;
        w_frame_err_d = 1'b0;
        w_pin_o_d     = r_pin_o;
        w_pin_oe_d    = r_pin_oe;

        unique case (r_state)
            IDLE: begin
                if (r_line_prev == LINE_IDLE && w_line != LINE_IDLE) begin
                    w_state_d = RX_START;
                    w_cnt_d   = CNT_HALF;
                end
            end
            RX_START: begin
                if (w_cnt_hit) begin
                    if (w_line != LINE_IDLE) begin
                        w_state_d = RX_DATA;
                        w_cnt_d   = CNT_FULL;
                        w_idx_d   = 4'd0;
                    end else begin
                        w_state_d = IDLE;
                    end
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (w_cnt_hit) begin
                    w_rx_shift_d = {w_line, r_rx_shift[FRAME_BITS-1:1]};
                    w_cnt_d      = CNT_FULL;
                    w_idx_d      = r_idx + 4'd1;
                    if (r_idx == IDX_LAST) begin
                        w_state_d = RX_STOP;
                    end
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (w_cnt_hit) begin
                    if (w_line == LINE_IDLE && w_par_ok) begin
                        w_rx_valid_d = 1'b1;
                        w_rx_data_d  = r_rx_shift[DATA_BITS-1:0];
                        if (resp_en) begin
                            w_state_d = TURN;
                            w_turn_d  = TURN_FULL;
                        end else begin
                            w_state_d = IDLE;
                        end
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_state_d     = (w_line == LINE_IDLE) ? IDLE : WAIT_HIGH;
                    end
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (w_line == LINE_IDLE) begin
                    w_state_d = IDLE;
                end
            end
            TURN: begin
                // First TURN cycle is the rx_valid cycle: that is when resp_data is captured.
                if (r_rx_valid) begin
                    w_tx_shift_d = w_tx_load;
                end
                if (r_turn == TURN_ONE) begin
                    w_state_d  = TX_START;
                    w_cnt_d    = CNT_FULL;
                    w_pin_oe_d = 1'b1;
                    w_pin_o_d  = 1'b0;
                end else begin
                    w_turn_d = r_turn - TURN_ONE;
                end
            end
            TX_START: begin
                if (w_cnt_hit) begin
                    w_state_d = TX_DATA;
                    w_cnt_d   = CNT_FULL;
                    w_idx_d   = 4'd0;
                    w_pin_o_d = r_tx_shift[0];
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (w_cnt_hit) begin
                    w_cnt_d      = CNT_FULL;
                    w_idx_d      = r_idx + 4'd1;
                    w_tx_shift_d = {LINE_IDLE, r_tx_shift[FRAME_BITS-1:1]};
                    if (r_idx == IDX_LAST) begin
                        w_state_d = TX_STOP;
                        w_pin_o_d = LINE_IDLE;
                    end else begin
                        w_pin_o_d = r_tx_shift[1];
                    end
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (w_cnt_hit) begin
                    w_state_d  = IDLE;
                    w_pin_oe_d = 1'b0;
                    w_pin_o_d  = LINE_IDLE;
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_d  = IDLE;
                w_pin_oe_d = 1'b0;
                w_pin_o_d  = LINE_IDLE;
            end
        endcase
    end

    // Pad controls are registered so pin_oe never glitches on state decode.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_turn      <= '0;
            r_idx       <= 4'd0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_pin_o     <= LINE_IDLE;
            r_pin_oe    <= 1'b0;
            r_line_prev <= LINE_IDLE;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_turn      <= w_turn_d;
            r_idx       <= w_idx_d;
            r_rx_shift  <= w_rx_shift_d;
            r_tx_shift  <= w_tx_shift_d;
            r_rx_data   <= w_rx_data_d;
            r_rx_valid  <= w_rx_valid_d;
            r_frame_err <= w_frame_err_d;
            r_pin_o     <= w_pin_o_d;
            r_pin_oe    <= w_pin_oe_d;
            r_line_prev <= w_line;
        end
    end

    assign pin_o     = r_pin_o;
    assign pin_oe    = r_pin_oe;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule
